mxu_data_feeder: RTL and testbench
==================================

// Module: mxu_data_feeder
// PURPOSE
// - Transmit side of the MXU MAC data path: drives the left-edge data inputs and clock enable of a systolic column of mxu_mac cells.
// - Accepts activation vectors over a valid/ready stream and skews them diagonally: lane r is delayed r*ROW_SKEW extra cycles.
// - Inserts zero bubbles when the stream stalls, flushes the skew lines after the last vector of a tile, then pulses done.
// PARAMETERS
// - bit_width  4  width of one activation lane, equal to the MAC bit_width
// - N_ROWS     4  number of MAC rows fed (lanes); >= 1
// - ROW_SKEW   1  extra delay stages per row index; >= 1
// PORTS
// - clk       in   1                 single clock, rising edge
// - reset     in   1                 asynchronous, active-low reset
// - s_valid   in   1                 input vector valid
// - s_ready   out  1                 feeder can accept a vector this cycle
// - s_data    in   N_ROWS*bit_width  lane r = s_data[r*bit_width +: bit_width]
// - s_last    in   1                 qualifies the last vector of a tile (sampled with s_valid)
// - mxu_data  out  N_ROWS*bit_width  skewed lane data to the mxu_mac data_input ports, same lane packing
// - mxu_valid out  N_ROWS            bit r = mxu_data lane r carries real data; 0 = bubble or flush zero
// - mxu_ce    out  1                 clock enable to the MAC array
// - busy      out  1                 tile in progress (state != IDLE)
// - done      out  1                 one-cycle pulse: last lane of the last vector is presented this cycle
// BEHAVIOUR
// - reset low (async): state IDLE; all skew registers, mxu_data, mxu_valid, mxu_ce, busy and done = 0; s_ready = 0 while reset is low.
// - FSM states: IDLE, FEED, FLUSH, DONE. accept = s_valid & s_ready.
// - s_ready = 1 in IDLE and FEED; 0 in FLUSH and DONE.
// - Transition IDLE -> FEED on accept with !s_last; IDLE -> FLUSH on accept with s_last.
// - Transition FEED -> FLUSH on accept with s_last; otherwise stay in FEED.
// - Transition FLUSH -> DONE after exactly (N_ROWS-1)*ROW_SKEW cycles; DONE -> IDLE after 1 cycle.
// - If N_ROWS = 1, a last-vector accept goes straight to DONE (skips FLUSH).
// - Skew lines: lane r is a shift chain of depth 1+r*ROW_SKEW. Each stage holds bit_width data plus 1 valid tag.
// - advance = accept | (state in {FEED, FLUSH}). All chains shift on advance; otherwise they hold.
// - Chain input on advance: s_data lane and tag 1 if accept; else zero data and tag 0. Bubbles and flush therefore inject zeros.
// - mxu_data lane r and mxu_valid[r] are the chain tails (registered outputs, no combinational path from s_*).
// - Latency: a vector accepted at the edge ending cycle T appears on lane r during cycle T+1+r*ROW_SKEW.
// - mxu_ce = 1 in FEED, FLUSH and DONE; 0 in IDLE. In DONE the final lane is presented with ce high.
// - busy = (state != IDLE). done = (state == DONE).
// - Stream rule: the sender holds s_data and s_last stable while s_valid=1 and s_ready=0. The feeder never drops an accepted vector.
// - Vectors presented in FLUSH or DONE are not accepted; they wait for IDLE.
// - No vector is lost at a tile boundary: a new tile starts in IDLE, one cycle after DONE.
// - Arithmetic: none on data; zeros are injected so bubbles add nothing to MAC partial sums.
// - Flush counter width: clog2((N_ROWS-1)*ROW_SKEW+1). It loads on entry to FLUSH and decrements to 0.
// - Reset mid-tile (any state): everything clears asynchronously; no done pulse; resume from IDLE.
// TESTING (N_ROWS=4, bit_width=4, ROW_SKEW=1 unless stated)
// - Reset: drive reset=0 with s_valid=1 -> all outputs 0 and s_ready=0; first cycle after release: s_ready=1, busy=0.
// - Single vector: lanes {3:4,2:3,1:2,0:1} + s_last, accepted end of T -> lane r = r+1 with mxu_valid[r]=1 in cycle T+1+r;
//   s_ready=0 in T+1..T+4; done=1 only in T+4; IDLE with ce=0 in T+5.
// - Back-to-back: 3 vectors k=0..2 (lane value 4k+r), s_valid held high, last on k=2 -> lane r shows 4k+r in cycle T+1+k+r;
//   done at T+6; never two valid tags for the same vector on one lane.
// - Bubble: s_valid=0 for one cycle between vectors 0 and 1 -> a zero diagonal with mxu_valid=0 walks through lanes 0..3;
//   mxu_ce stays 1; vector 1 is delayed by exactly 1 cycle.
// - Back-pressure: s_valid=1 with a new vector during FLUSH/DONE -> not accepted; accepted in the first IDLE cycle; order preserved.
// - Reset mid-FLUSH: reset=0 one cycle into FLUSH -> outputs 0 immediately; no done; after release, a new tile runs normally.
// - Param ROW_SKEW=2, N_ROWS=3: single last vector at T -> lane r valid in cycle T+1+2r; done at T+5; FLUSH lasts 4 cycles.

Source files
------------

// File: rtl/mxu_data_feeder.sv
// Feeds a systolic column of MAC cells from a valid/ready stream. Each lane is delayed by
// r*ROW_SKEW extra cycles, and the skew lines are flushed with zeros after the last vector of a tile.
module mxu_data_feeder #(
  parameter int unsigned bit_width = 4,
  parameter int unsigned N_ROWS    = 4,
  parameter int unsigned ROW_SKEW  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_ROWS*bit_width-1:0]   s_data,
  input  logic                          s_last,
  output logic [N_ROWS*bit_width-1:0]   mxu_data,
  output logic [N_ROWS-1:0]             mxu_valid,
  output logic                          mxu_ce,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned FlushCycles = (N_ROWS - 1) * ROW_SKEW;
  localparam int unsigned CntW        = (FlushCycles > 0) ? $clog2(FlushCycles + 1) : 1;

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDone} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_flush_cnt;
  logic            w_accept;
  logic            w_advance;

  // Ready is forced low while reset is asserted, not just once the state has cleared.
  assign s_ready   = reset & ((r_state == StIdle) | (r_state == StFeed));
  assign w_accept  = s_valid & s_ready;
  assign w_advance = w_accept | (r_state == StFeed) | (r_state == StFlush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_flush_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle, StFeed: begin
          if (w_accept) begin
            if (!s_last) begin
              r_state <= StFeed;
            end else if (FlushCycles == 0) begin
              r_state <= StDone;
            end else begin
              r_state     <= StFlush;
              r_flush_cnt <= CntW'(FlushCycles);
            end
          end
        end
        StFlush: begin
          r_flush_cnt <= r_flush_cnt - CntW'(1);
          if (r_flush_cnt == CntW'(1)) begin
            r_state <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy   = (r_state != StIdle);
  assign mxu_ce = (r_state != StIdle);
  assign done   = (r_state == StDone);

  for (genvar r = 0; r < N_ROWS; r++) begin : g_lane
    localparam int unsigned Depth = 1 + r * ROW_SKEW;

    logic [bit_width-1:0] r_dat [Depth];
    logic [Depth-1:0]     r_vld;

    // Bubbles and flush cycles push zero data with a cleared tag so MAC sums are unaffected.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_vld <= '0;
        for (int i = 0; i < Depth; i++) begin
          r_dat[i] <= '0;
        end
      end else if (w_advance) begin
        r_dat[0] <= w_accept ? s_data[r*bit_width +: bit_width] : '0;
        r_vld[0] <= w_accept;
        for (int i = 1; i < Depth; i++) begin
          r_dat[i] <= r_dat[i-1];
          r_vld[i] <= r_vld[i-1];
        end
      end
    end

    assign mxu_data[r*bit_width +: bit_width] = r_dat[Depth-1];
    assign mxu_valid[r]                       = r_vld[Depth-1];
  end

endmodule

// File: tb/tb_mxu_data_feeder.sv
// Randomized bench for mxu_data_feeder: two configurations (4 rows/skew 1 and 3 rows/skew 2)
// checked against a cycle-timeline model built from accept times and the lane latency rule.
module tb_mxu_data_feeder;

  localparam int Inf  = 1 << 30;
  localparam int MaxC = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, s_last;
  logic [15:0] s_data;
  logic        sel;

  logic        a_ready, a_ce, a_busy, a_done;
  logic [15:0] a_data;
  logic [3:0]  a_mv;
  logic        b_ready, b_ce, b_busy, b_done;
  logic [11:0] b_data;
  logic [2:0]  b_mv;

  logic        o_ready, o_ce, o_busy, o_done;
  logic [15:0] o_data;
  logic [3:0]  o_mv;

  always #5 clk = ~clk;

  mxu_data_feeder #(.bit_width(4), .N_ROWS(4), .ROW_SKEW(1)) u_dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .s_valid   (a_valid),
    .s_ready   (a_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .mxu_data  (a_data),
    .mxu_valid (a_mv),
    .mxu_ce    (a_ce),
    .busy      (a_busy),
    .done      (a_done)
  );

  mxu_data_feeder #(.bit_width(4), .N_ROWS(3), .ROW_SKEW(2)) u_dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .s_valid   (b_valid),
    .s_ready   (b_ready),
    .s_data    (s_data[11:0]),
    .s_last    (s_last),
    .mxu_data  (b_data),
    .mxu_valid (b_mv),
    .mxu_ce    (b_ce),
    .busy      (b_busy),
    .done      (b_done)
  );

  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_ce    = sel ? b_ce    : a_ce;
    o_busy  = sel ? b_busy  : a_busy;
    o_done  = sel ? b_done  : a_done;
    o_data  = sel ? {4'b0, b_data} : a_data;
    o_mv    = sel ? {1'b0, b_mv}   : a_mv;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: accept history plus the timeline of the open tile.
  int          n_rows, skew;
  bit          acc_v [MaxC];
  logic [15:0] acc_d [MaxC];
  bit          open;
  int          dc;
  int          base;

  logic [15:0] vq[$];
  bit          lq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, o_ready, 0);
    check({pfx, "_busy"},  o_busy,  0);
    check({pfx, "_ce"},    o_ce,    0);
    check({pfx, "_done"},  o_done,  0);
    check({pfx, "_valid"}, o_mv,    0);
    check({pfx, "_data"},  o_data,  0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    #2;
    check_reset_outputs("rst_async");
    @(posedge clk); #1;
    check_reset_outputs("rst_hold");
    rst_n   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    open    = 1'b0;
    dc      = Inf;
    base    = cyc;
  endtask

  // One clock cycle: present inputs, check outputs mid-cycle, update the model at the edge.
  task automatic step(input bit v, input logic [15:0] d, input bit l, output bit accepted);
    int c, idx;
    bit rdy, ev;
    logic [3:0] ed;
    if (sel) b_valid = v; else a_valid = v;
    s_data = d;
    s_last = l;
    @(negedge clk);
    c   = cyc;
    rdy = !(open && dc != Inf);
    check("s_ready", o_ready, rdy);
    check("busy",    o_busy,  open);
    check("mxu_ce",  o_ce,    open);
    check("done",    o_done,  open && c == dc);
    if (open) begin
      for (int r = 0; r < n_rows; r++) begin
        idx = c - 1 - r * skew;
        ev  = (idx >= base) && acc_v[idx];
        ed  = ev ? acc_d[idx][r*4 +: 4] : 4'd0;
        check($sformatf("lane%0d_valid", r), o_mv[r], ev);
        check($sformatf("lane%0d_data", r), o_data[r*4 +: 4], ed);
      end
    end
    accepted = v && rdy;
    if (c < MaxC) begin
      acc_v[c] = accepted;
      acc_d[c] = d;
    end
    if (accepted) begin
      if (!open) begin
        open = 1'b1;
        dc   = Inf;
      end
      if (l) dc = c + 1 + (n_rows - 1) * skew;
    end else if (open && c == dc) begin
      open = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic push_tile(input int nvec);
    for (int k = 0; k < nvec; k++) begin
      vq.push_back(16'($urandom()));
      lq.push_back(k == nvec - 1);
    end
  endtask

  // Sender holds the head vector until it is accepted.
  task automatic drive(input int bubble_pct);
    int guard;
    bit v, acc;
    guard = 0;
    while (vq.size() > 0 && guard < 2000) begin
      v = ($urandom_range(99) >= bubble_pct);
      step(v, vq[0], lq[0], acc);
      if (acc) begin
        void'(vq.pop_front());
        void'(lq.pop_front());
      end
      guard++;
    end
  endtask

  task automatic drain();
    int g;
    bit acc;
    g = 0;
    while (open && g < 200) begin
      step(1'b0, 16'h0, 1'b0, acc);
      g++;
    end
    step(1'b0, 16'h0, 1'b0, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    sel = 1'b0; n_rows = 4; skew = 1;
    a_valid = 1'b0; b_valid = 1'b0; s_last = 1'b0; s_data = '0; rst_n = 1'b0;
    open = 1'b0; dc = Inf; base = 0;
    do_reset();

    // Single last vector, lanes 1..4.
    vq.push_back(16'h4321); lq.push_back(1'b1);
    drive(0);
    drain();

    // Back-to-back tile of three vectors, lane value 4k+r.
    vq.push_back(16'h3210); lq.push_back(1'b0);
    vq.push_back(16'h7654); lq.push_back(1'b0);
    vq.push_back(16'hBA98); lq.push_back(1'b1);
    drive(0);
    drain();

    // One-cycle bubble between vectors.
    step(1'b1, 16'h3210, 1'b0, acc);
    step(1'b0, 16'h0000, 1'b0, acc);
    step(1'b1, 16'h7654, 1'b1, acc);
    drain();

    // Next tile offered during FLUSH/DONE must wait for IDLE.
    push_tile(2);
    push_tile(3);
    drive(0);
    drain();

    // Random tiles, back to back, with random bubbles.
    for (int t = 0; t < 20; t++) push_tile($urandom_range(1, 6));
    drive(30);
    drain();

    // Reset one cycle into FLUSH, then a normal tile.
    push_tile(2);
    drive(0);
    step(1'b0, 16'h0, 1'b0, acc);
    do_reset();
    push_tile(3);
    drive(20);
    drain();

    // Second configuration: 3 rows, skew 2.
    sel = 1'b1; n_rows = 3; skew = 2;
    do_reset();
    vq.push_back(16'h0321); lq.push_back(1'b1);
    drive(0);
    drain();
    for (int t = 0; t < 15; t++) push_tile($urandom_range(1, 5));
    drive(25);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
